// File: rtl/regfile_pkg.sv
// Shared widths, producer ids and the write-request payload for the register-file write-back path.
package regfile_pkg;

   localparam int unsigned DATA_WIDTH = 64;
   localparam int unsigned REG_COUNT  = 32;
   localparam int unsigned ADDR_WIDTH = $clog2(REG_COUNT);

   typedef enum logic {
      PROD_ALU = 1'b0,
      PROD_MEM = 1'b1
   } prod_e;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/wb_rr_arb2.sv
// Two-request round-robin arbiter; req/grant bit 0 is ALU and bit 1 is MEM.
// A port's grant depends only on the other port's request, so Ready never depends on its own Valid.
module wb_rr_arb2
   import regfile_pkg::*;
(
   input  logic       Clk,
   input  logic       Rst_N,
   input  logic [1:0] req,
   output logic [1:0] grant
);

   prod_e last_q;
   prod_e last_d;

   always_comb begin
      grant  = 2'b00;
      last_d = last_q;
      if (Rst_N) begin
         grant[0] = !req[1] || (last_q == PROD_MEM);
         grant[1] = !req[0] || (last_q == PROD_ALU);
      end
      // Remember the winner only when a transfer actually happens
      if (req[1] && grant[1]) begin
         last_d = PROD_MEM;
      end else if (req[0] && grant[0]) begin
         last_d = PROD_ALU;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst_N) begin
         last_q <= PROD_ALU;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-back front end: ALU/MEM arbitration, registered write port and busy scoreboard.
// Optional macro WB_ZERO_REG_EN hardwires register 0 (no writes, never busy).
module regfile_writeback
   import regfile_pkg::*;
(
   input  logic                  Clk,
   input  logic                  Rst_N,
   input  logic                  rsv_Valid,
   input  logic [ADDR_WIDTH-1:0] rsv_Addr,
   input  logic                  alu_Valid,
   output logic                  alu_Ready,
   input  logic [ADDR_WIDTH-1:0] alu_Addr,
   input  logic [DATA_WIDTH-1:0] alu_Data,
   input  logic                  mem_Valid,
   output logic                  mem_Ready,
   input  logic [ADDR_WIDTH-1:0] mem_Addr,
   input  logic [DATA_WIDTH-1:0] mem_Data,
   output logic                  write_En,
   output logic [ADDR_WIDTH-1:0] writeAddr,
   output logic [DATA_WIDTH-1:0] data_in,
   output logic [REG_COUNT-1:0]  busy_Vec
);

   logic [1:0]            grant;
   logic                  fire_alu;
   logic                  fire_mem;
   wb_req_t               sel;
   logic                  write_en_q, write_en_d;
   logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
   logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
   logic [REG_COUNT-1:0]  busy_q, busy_d;

   wb_rr_arb2 u_arb (
      .Clk   (Clk),
      .Rst_N (Rst_N),
      .req   ({mem_Valid, alu_Valid}),
      .grant (grant)
   );

   assign alu_Ready = grant[0];
   assign mem_Ready = grant[1];

   always_comb begin
      fire_alu     = alu_Valid && alu_Ready;
      fire_mem     = mem_Valid && mem_Ready;
      sel          = fire_mem ? wb_req_t'{addr: mem_Addr, data: mem_Data}
                              : wb_req_t'{addr: alu_Addr, data: alu_Data};
      write_en_d   = fire_alu || fire_mem;
`ifdef WB_ZERO_REG_EN
      write_en_d   = write_en_d && (sel.addr != ADDR_WIDTH'(0));
`endif
      write_addr_d = (fire_alu || fire_mem) ? sel.addr : write_addr_q;
      write_data_d = (fire_alu || fire_mem) ? sel.data : write_data_q;

      // Clear on the commit edge first so a same-edge reservation wins
      busy_d = busy_q;
      if (write_en_q) begin
         busy_d[write_addr_q] = 1'b0;
      end
      if (rsv_Valid) begin
         busy_d[rsv_Addr] = 1'b1;
      end
`ifdef WB_ZERO_REG_EN
      busy_d[0] = 1'b0;
`endif
   end

   always_ff @(posedge Clk) begin
      if (!Rst_N) begin
         write_en_q   <= 1'b0;
         write_addr_q <= '0;
         write_data_q <= '0;
         busy_q       <= '0;
      end else begin
         write_en_q   <= write_en_d;
         write_addr_q <= write_addr_d;
         write_data_q <= write_data_d;
         busy_q       <= busy_d;
      end
   end

   assign write_En  = write_en_q;
   assign writeAddr = write_addr_q;
   assign data_in   = write_data_q;
   assign busy_Vec  = busy_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback (expected values computed by hand).
module tb_regfile_writeback;
   import regfile_pkg::*;

   logic                  Clk;
   logic                  Rst_N;
   logic                  rsv_Valid;
   logic [ADDR_WIDTH-1:0] rsv_Addr;
   logic                  alu_Valid;
   logic                  alu_Ready;
   logic [ADDR_WIDTH-1:0] alu_Addr;
   logic [DATA_WIDTH-1:0] alu_Data;
   logic                  mem_Valid;
   logic                  mem_Ready;
   logic [ADDR_WIDTH-1:0] mem_Addr;
   logic [DATA_WIDTH-1:0] mem_Data;
   logic                  write_En;
   logic [ADDR_WIDTH-1:0] writeAddr;
   logic [DATA_WIDTH-1:0] data_in;
   logic [REG_COUNT-1:0]  busy_Vec;

   int total = 0;
   int bad   = 0;

   regfile_writeback dut (
      .Clk       (Clk),
      .Rst_N     (Rst_N),
      .rsv_Valid (rsv_Valid),
      .rsv_Addr  (rsv_Addr),
      .alu_Valid (alu_Valid),
      .alu_Ready (alu_Ready),
      .alu_Addr  (alu_Addr),
      .alu_Data  (alu_Data),
      .mem_Valid (mem_Valid),
      .mem_Ready (mem_Ready),
      .mem_Addr  (mem_Addr),
      .mem_Data  (mem_Data),
      .write_En  (write_En),
      .writeAddr (writeAddr),
      .data_in   (data_in),
      .busy_Vec  (busy_Vec)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are sampled 1ns after it
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Let combinational Ready settle after an input change
   task automatic settle();
      #1;
   endtask

   task automatic check_wr(input string tag, input logic en, input logic [ADDR_WIDTH-1:0] a,
                           input logic [DATA_WIDTH-1:0] d);
      chk({tag, "_en"}, 64'(write_En), 64'(en));
      chk({tag, "_addr"}, 64'(writeAddr), 64'(a));
      chk({tag, "_data"}, data_in, d);
   endtask

   initial begin
      Rst_N = 1'b0; rsv_Valid = 1'b1; rsv_Addr = 5'd3;
      alu_Valid = 1'b1; alu_Addr = 5'd1; alu_Data = 64'h11;
      mem_Valid = 1'b1; mem_Addr = 5'd2; mem_Data = 64'h22;

      // 1. reset with everything requesting
      tick(); tick();
      check_wr("rst", 1'b0, 5'd0, 64'h0);
      chk("rst_alu_rdy", 64'(alu_Ready), 64'h0);
      chk("rst_mem_rdy", 64'(mem_Ready), 64'h0);
      chk("rst_busy", 64'(busy_Vec), 64'h0);

      Rst_N = 1'b1; rsv_Valid = 1'b0; alu_Valid = 1'b0; mem_Valid = 1'b0;
      tick();
      chk("idle_busy", 64'(busy_Vec), 64'h0);
      chk("idle_we", 64'(write_En), 64'h0);

      // 2. single ALU write to r5
      rsv_Valid = 1'b1; rsv_Addr = 5'd5;
      tick();
      rsv_Valid = 1'b0;
      chk("rsv5_busy", 64'(busy_Vec), 64'h20);
      alu_Valid = 1'b1; alu_Addr = 5'd5; alu_Data = 64'hDEAD_BEEF;
      settle();
      chk("alu5_rdy", 64'(alu_Ready), 64'h1);
      tick();
      alu_Valid = 1'b0;
      check_wr("alu5_wr", 1'b1, 5'd5, 64'hDEAD_BEEF);
      chk("alu5_busy_pend", 64'(busy_Vec), 64'h20);
      tick();
      chk("alu5_we_off", 64'(write_En), 64'h0);
      chk("alu5_busy_clr", 64'(busy_Vec), 64'h0);

      // 3. contention: reserve r1..r4, then both producers stream
      for (int r = 1; r <= 4; r++) begin
         rsv_Valid = 1'b1; rsv_Addr = ADDR_WIDTH'(r);
         tick();
      end
      rsv_Valid = 1'b0;
      chk("rsv14_busy", 64'(busy_Vec), 64'h1E);
      alu_Valid = 1'b1; alu_Addr = 5'd1; alu_Data = 64'hA1;
      mem_Valid = 1'b1; mem_Addr = 5'd2; mem_Data = 64'hB2;
      settle();
      chk("c1_mem_rdy", 64'(mem_Ready), 64'h1);
      chk("c1_alu_rdy", 64'(alu_Ready), 64'h0);
      tick();
      mem_Addr = 5'd4; mem_Data = 64'hB4;
      settle();
      check_wr("c1_wr", 1'b1, 5'd2, 64'hB2);
      chk("c2_alu_rdy", 64'(alu_Ready), 64'h1);
      chk("c2_mem_rdy", 64'(mem_Ready), 64'h0);
      tick();
      alu_Addr = 5'd3; alu_Data = 64'hA3;
      settle();
      check_wr("c2_wr", 1'b1, 5'd1, 64'hA1);
      chk("c2_busy", 64'(busy_Vec), 64'h1A);
      chk("c3_mem_rdy", 64'(mem_Ready), 64'h1);
      tick();
      mem_Valid = 1'b0;
      settle();
      check_wr("c3_wr", 1'b1, 5'd4, 64'hB4);
      chk("c4_alu_rdy", 64'(alu_Ready), 64'h1);
      tick();
      alu_Valid = 1'b0;
      check_wr("c4_wr", 1'b1, 5'd3, 64'hA3);
      chk("c4_busy", 64'(busy_Vec), 64'h08);
      tick();
      chk("c5_we_off", 64'(write_En), 64'h0);
      chk("c5_busy", 64'(busy_Vec), 64'h0);

      // 4. same-edge reserve and commit of r7: set wins
      rsv_Valid = 1'b1; rsv_Addr = 5'd7;
      tick();
      rsv_Valid = 1'b0;
      alu_Valid = 1'b1; alu_Addr = 5'd7; alu_Data = 64'h77;
      tick();
      alu_Valid = 1'b0;
      check_wr("r7_wr", 1'b1, 5'd7, 64'h77);
      rsv_Valid = 1'b1; rsv_Addr = 5'd7;
      tick();
      rsv_Valid = 1'b0;
      chk("r7_busy_kept", 64'(busy_Vec), 64'h80);
      chk("r7_we_off", 64'(write_En), 64'h0);

      // 5. reset in the cycle after an accept drops the write
      rsv_Valid = 1'b1; rsv_Addr = 5'd9;
      tick();
      rsv_Valid = 1'b0;
      alu_Valid = 1'b1; alu_Addr = 5'd9; alu_Data = 64'h99;
      tick();
      alu_Valid = 1'b0;
      chk("r9_inflight", 64'(write_En), 64'h1);
      chk("r9_busy", 64'(busy_Vec), 64'h280);
      Rst_N = 1'b0;
      tick();
      Rst_N = 1'b1;
      check_wr("rst2", 1'b0, 5'd0, 64'h0);
      chk("rst2_busy", 64'(busy_Vec), 64'h0);
      // rr_last back to ALU: MEM wins a tie
      alu_Valid = 1'b1; mem_Valid = 1'b1;
      settle();
      chk("rst2_mem_rdy", 64'(mem_Ready), 64'h1);
      chk("rst2_alu_rdy", 64'(alu_Ready), 64'h0);
      alu_Valid = 1'b0; mem_Valid = 1'b0;
      settle();

      // 6. register 0 handling, with a reservation to r0 in the same cycle
      alu_Valid = 1'b1; alu_Addr = 5'd0; alu_Data = 64'hABCD;
      rsv_Valid = 1'b1; rsv_Addr = 5'd0;
      settle();
      chk("r0_rdy", 64'(alu_Ready), 64'h1);
      tick();
      alu_Valid = 1'b0; rsv_Valid = 1'b0;
`ifdef WB_ZERO_REG_EN
      chk("r0_we", 64'(write_En), 64'h0);
      chk("r0_busy", 64'(busy_Vec), 64'h0);
`else
      check_wr("r0_wr", 1'b1, 5'd0, 64'hABCD);
      chk("r0_busy", 64'(busy_Vec), 64'h1);
`endif
      tick();
      chk("r0_busy_after", 64'(busy_Vec), 64'h0);
      chk("r0_we_after", 64'(write_En), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
